mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  issue request for a MULTU/DIVU instruction.
REQ-005 op  input  1  0 = MULTU, 1 = DIVU; sampled with start.
REQ-006 srca  input  WIDTH  multiplicand or dividend (rs), sampled with start.
REQ-007 srcb  input  WIDTH  multiplier or divisor (rt), sampled with start.
REQ-008 mf_req  input  1  MFHI/MFLO read request.
REQ-009 mf_sel  input  1  0 = HI, 1 = LO.
REQ-010 mf_data  output  WIDTH  combinational: LO if mf_sel = 1, else HI.
REQ-011 busy  output  1  high while an operation is iterating.
REQ-012 stall  output  1  combinational: busy AND (start OR mf_req); freezes the PC and instruction.
REQ-013 done  output  1  one-cycle pulse in the cycle after HI/LO update.
REQ-014 dz  output  1  sticky divide-by-zero flag; cleared by the next accepted start.
REQ-015 hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-016 FSM states: IDLE, MUL, DIV, DONE; busy = 1 in MUL and DIV only.
REQ-017 start SHALL be accepted only in IDLE or DONE; acceptance latches operands, clears dz, zeroes the iteration counter, and moves to MUL (op = 0) or DIV (op = 1).
REQ-018 start in MUL or DIV SHALL be ignored, with stall held high until the state leaves MUL/DIV.
REQ-019 MUL: unsigned radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
REQ-020 DIV: unsigned restoring division, one quotient bit per cycle; quotient goes to LO, remainder to HI.
REQ-021 Each MUL/DIV cycle increments the counter; the edge completing iteration WIDTH-1 writes HI/LO and enters DONE.
REQ-022 Latency: for start accepted at edge T0, HI/LO are written at edge T0+WIDTH (T0+32 at default) and done = 1 for the following cycle.
REQ-023 DONE SHALL return to IDLE after one cycle, unless start is accepted in DONE.
REQ-024 DIVU with srcb = 0 SHALL skip iteration: at the acceptance edge write LO = all ones and HI = srca, set dz, and enter DONE (latency 1).
REQ-025 HI/LO SHALL change only on completion; intermediate results stay in internal registers, so mf_data is never partial.
REQ-026 mf_req in IDLE or DONE SHALL have no stall; mf_data in the DONE cycle reflects the new result.
REQ-027 Operand changes after acceptance SHALL NOT affect the result.
REQ-028 Product/quotient are exact modulo 2^(2*WIDTH); no overflow indication.

Reset
REQ-029 Asynchronous reset SHALL force IDLE, counter = 0, hi = lo = 0, busy = done = dz = 0, and clear internal accumulators.
REQ-030 Reset mid-operation SHALL abort the operation without updating HI/LO beyond the reset clear; the first start after reset release is accepted normally.

Structure
REQ-031 Package mdu_pkg SHALL hold the state enumeration, the op encodings (OP_MULTU = 0, OP_DIVU = 1), and the default ITER = 32 constant.
REQ-032 One sub-module mdu_step SHALL implement a single combinational iteration (conditional add for MUL, trial subtract for DIV); the sequencer instantiates it once.
REQ-033 Integration: replaces the combinational multiply and load-enabled HI/LO registers; stall gates the PC register enable.

Verification
REQ-034 MULTU 3 x 5, start at edge T0 -> busy for 32 cycles; at T0+32 hi = 0, lo = 15; done pulses once.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-036 DIVU 100 / 7 -> lo = 14, hi = 2, dz = 0; DIVU 0x12345678 / 0 -> after 1 cycle lo = 0xFFFFFFFF, hi = 0x12345678, dz = 1.
REQ-037 mf_req (mf_sel = 1) one cycle after start -> stall = 1 until DONE; mf_data in DONE = new lo.
REQ-038 Back-to-back starts, second held during busy -> stall high, second accepted in DONE, both results correct in sequence.
REQ-039 Reset asserted at iteration 10 of a MULTU -> next cycle busy = 0, hi = lo = 0; a subsequent MULTU 6 x 7 gives lo = 42.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared sequencer state encoding, op encodings and default iteration count
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU = 1'b1;
  localparam int ITER = 32;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add multiply or restoring-divide iteration; ports op, acc {upper,lower}, b operand, nxt accumulator
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum, dif;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b & {WIDTH{acc[0]}}};
    dif = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
    nxt = (op == OP_DIVU)
        ? (dif[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
        : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential MULTU/DIVU unit with HI/LO; ports clk, reset, start/op/srca/srcb issue, mf_req/mf_sel/mf_data read, busy/stall/done/dz status, hi/lo
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [WIDTH-1:0]   b;
  logic               accept;
  assign accept  = start & (state == IDLE | state == DONE);
  assign stall   = busy & (start | mf_req);
  assign mf_data = mf_sel ? lo : hi;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op (state == DIV),
    .acc(acc),
    .b  (b),
    .nxt(nxt)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      b     <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dz  <= 1'b0;
        cnt <= '0;
        acc <= {{WIDTH{1'b0}}, srca};
        b   <= srcb;
        if (op == OP_DIVU && srcb == '0) begin
          hi    <= srca;
          lo    <= '1;
          dz    <= 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          busy  <= 1'b1;
          state <= (op == OP_DIVU) ? DIV : MUL;
        end
      end else if (busy) begin
        acc <= nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          hi    <= nxt[2*WIDTH-1:WIDTH];
          lo    <= nxt[WIDTH-1:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized and directed checks of mdu_seq against a cycle-level arithmetic model
module tb_mdu_seq;
  localparam int W = 32;
  logic clk = 0, reset = 1, start = 0, op = 0, mf_req = 0, mf_sel = 0;
  logic [W-1:0] srca = 0, srcb = 0, mf_data, hi, lo;
  logic busy, stall, done, dz;
  int checks = 0, errors = 0;
  int rem = 0;
  logic [W-1:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic m_dz = 0, m_done = 0;
  logic s_done, s_busy, s_dz;
  logic [W-1:0] s_hi, s_lo, s_mf;
  int n, nb;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .busy(busy), .stall(stall),
    .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic eb;
    eb = rem > 0;
    chk("busy", 64'(busy), 64'(eb));
    chk("done", 64'(done), 64'(m_done));
    chk("dz", 64'(dz), 64'(m_dz));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("stall", 64'(stall), 64'(eb & (start | mf_req)));
    chk("mf_data", 64'(mf_data), 64'(mf_sel ? m_lo : m_hi));
  endtask

  task automatic model_reset();
    rem = 0; m_hi = 0; m_lo = 0; m_dz = 0; m_done = 0;
  endtask

  task automatic model_step();
    logic [63:0] prod;
    m_done = 0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1;
      end
    end else if (start) begin
      m_dz = 0;
      if (op && srcb == 0) begin
        m_hi = srca; m_lo = '1; m_dz = 1; m_done = 1;
      end else begin
        if (op) begin
          p_lo = srca / srcb; p_hi = srca % srcb;
        end else begin
          prod = 64'(srca) * 64'(srcb);
          p_hi = prod[63:32]; p_lo = prod[31:0];
        end
        rem = W;
      end
    end
  endtask

  task automatic cyc(input logic s, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic mr, input logic ms);
    @(negedge clk);
    start = s; op = o; srca = a; srcb = b; mf_req = mr; mf_sel = ms;
    #1;
    compare();
    s_done = done; s_busy = busy; s_dz = dz; s_hi = hi; s_lo = lo; s_mf = mf_data;
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; mf_req = 0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_done(input logic s, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic mr, input logic ms);
    n = 0; nb = 0; s_done = 0;
    while (!s_done && n < 40) begin
      cyc(s, o, a, b, mr, ms);
      n++;
      nb += int'(s_busy);
    end
    chk("done_seen", 64'(s_done), 64'd1);
  endtask

  initial begin
    #1;
    model_reset();
    compare();
    do_reset();
    // MULTU 3 x 5: latency and busy length
    cyc(1, 0, 3, 5, 0, 0);
    wait_done(0, 0, 0, 0, 0, 0);
    chk("mul3x5_lat", 64'(n), 64'd33);
    chk("mul3x5_busy", 64'(nb), 64'd32);
    chk("mul3x5_hi", 64'(s_hi), 64'd0);
    chk("mul3x5_lo", 64'(s_lo), 64'd15);
    cyc(0, 0, 0, 0, 0, 0);
    chk("mul3x5_done_once", 64'(s_done), 64'd0);
    // MULTU max x max
    cyc(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    wait_done(0, 0, $urandom, $urandom, 0, 0);
    chk("mulmax_hi", 64'(s_hi), 64'hFFFFFFFE);
    chk("mulmax_lo", 64'(s_lo), 64'h00000001);
    // DIVU 100 / 7
    cyc(1, 1, 100, 7, 0, 0);
    wait_done(0, 1, 5, 0, 0, 0);
    chk("div_lo", 64'(s_lo), 64'd14);
    chk("div_hi", 64'(s_hi), 64'd2);
    chk("div_dz", 64'(s_dz), 64'd0);
    // DIVU by zero
    cyc(1, 1, 32'h12345678, 0, 0, 0);
    wait_done(0, 0, 0, 0, 0, 0);
    chk("dz_lat", 64'(n), 64'd1);
    chk("dz_lo", 64'(s_lo), 64'hFFFFFFFF);
    chk("dz_hi", 64'(s_hi), 64'h12345678);
    chk("dz_flag", 64'(s_dz), 64'd1);
    // mf_req during busy, read LO in DONE
    cyc(1, 0, 9, 11, 0, 0);
    wait_done(0, 0, 0, 0, 1, 1);
    chk("mf_lo_done", 64'(s_mf), 64'd99);
    chk("dz_cleared", 64'(s_dz), 64'd0);
    // back-to-back: second start held through busy
    cyc(1, 0, 1000, 1000, 0, 0);
    wait_done(1, 1, 100, 7, 0, 0);
    chk("b2b_first_lo", 64'(s_lo), 64'd1000000);
    wait_done(0, 0, 0, 0, 0, 0);
    chk("b2b_second_lo", 64'(s_lo), 64'd14);
    chk("b2b_second_hi", 64'(s_hi), 64'd2);
    // reset mid-operation then MULTU 6 x 7
    cyc(1, 0, 32'hDEADBEEF, 32'h1234, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_hi", 64'(s_hi), 64'd0);
    chk("rst_lo", 64'(s_lo), 64'd0);
    cyc(1, 0, 6, 7, 0, 0);
    wait_done(0, 0, 0, 0, 0, 0);
    chk("mul6x7_lo", 64'(s_lo), 64'd42);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] b;
      b = ($urandom % 6 == 0) ? 0 : (($urandom % 3 == 0) ? 32'($urandom % 16) : $urandom);
      if ($urandom % 1500 == 0) do_reset();
      cyc(($urandom % 6) == 0, 1'($urandom), $urandom, b, 1'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
